// File: rtl/pegasus_pkg.sv
// Shared definitions for the instruction-memory side of the core.
//   IMEM_DEPTH     : number of 32-bit instruction words in IMEM
//   INSTR_W        : instruction width in bits
//   loader_state_e : state encoding of the program loader FSM
// Imported by imem_loader_if, imem_word_packer and imem_loader.
package pegasus_pkg;

  localparam int IMEM_DEPTH = 64;
  localparam int INSTR_W    = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_WRITE   = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the program loader.
//   byte_valid / byte_data / byte_ready : host byte stream (transfer = valid & ready)
//   imem_we / imem_waddr / imem_wdata   : one-cycle word write into IMEM
// Modports:
//   master : host / IMEM side (drives the stream, observes the writes)
//   slave  : loader side (accepts the stream, drives the writes)
interface imem_loader_if #(
  parameter int ADDR_W = 32
) ();

  logic                           byte_valid;
  logic [7:0]                     byte_data;
  logic                           byte_ready;
  logic                           imem_we;
  logic [ADDR_W-1:0]              imem_waddr;
  logic [pegasus_pkg::INSTR_W-1:0] imem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Packs four consecutive stream bytes into one little-endian instruction word.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart packing at byte 0 (issued when a load starts)
//   byte_en      : a payload byte is transferred this cycle
//   byte_data    : the transferred byte
//   word         : completed word; valid only while word_ready is high
//   word_ready   : high in the cycle the 4th byte of a word is transferred
// The first three bytes are held in a shift register; the completed word is
// formed combinationally from the 4th byte so the loader can capture it in
// the same cycle and move straight to its write state.
module imem_word_packer
  import pegasus_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               byte_en,
  input  logic [7:0]         byte_data,
  output logic [INSTR_W-1:0] word,
  output logic               word_ready
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // Newest byte enters at the top, so after three bytes byte 0 sits in [7:0].
  assign word       = {byte_data, shift_q};
  assign word_ready = byte_en && (byte_cnt == 2'd3);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples values from before the clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= 2'd0;
      shift_q  <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;  // wraps to 0 after the 4th byte
      shift_q  <= {byte_data, shift_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives a byte stream from the host link, packs it into
// 32-bit instructions and writes them to IMEM from word 0 upward, holding the
// core in reset (cpu_hold) while loading.
// Stream format: header byte N (word count, 1..DEPTH), then 4*N payload bytes,
// least significant byte of each word first.
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN): one trailing byte after the
// last word must equal the XOR of the header and all payload bytes.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start        : one-cycle pulse; starts a load from IDLE or DONE
//   bus          : imem_loader_if.slave (byte stream in, IMEM write port out)
//   cpu_hold     : high while a load is in progress
//   busy         : FSM is neither IDLE nor DONE
//   done         : sticky, load completed correctly; cleared by start
//   error        : sticky, bad header or checksum; cleared by start
module imem_loader
  import pegasus_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         busy,
  output logic         done,
  output logic         error
);

  // Word counter must be able to hold DEPTH itself (the final count).
  localparam int         CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [8:0] DEPTH_LIM = 9'(DEPTH);

  loader_state_e      state;
  logic [CNT_W-1:0]   n_words;
  logic [CNT_W-1:0]   word_idx;
  logic               we_q;
  logic [ADDR_W-1:0]  waddr_q;
  logic [INSTR_W-1:0] wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum;
`endif

  logic               byte_ready_c;
  logic               xfer;
  logic               start_ok;
  logic [INSTR_W-1:0] packed_word;
  logic               word_ready;

  // byte_ready depends on the state register only, never on byte_valid.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_ready_c = 1'b0;
    busy         = 1'b1;
    case (state)
      ST_HEADER, ST_PAYLOAD: byte_ready_c = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK:              byte_ready_c = 1'b1;
`endif
      ST_IDLE, ST_DONE:      busy = 1'b0;
      default:               ;
    endcase
  end

  assign xfer     = bus.byte_valid && byte_ready_c;
  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));

  assign bus.byte_ready = byte_ready_c;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;

  imem_word_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (start_ok),
    .byte_en    (xfer && (state == ST_PAYLOAD)),
    .byte_data  (bus.byte_data),
    .word       (packed_word),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      n_words  <= '0;
      word_idx <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      // Write strobe is only ever set for the single WRITE cycle.
      we_q <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_HEADER;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            word_idx <= '0;
          end
        end

        ST_HEADER: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= bus.byte_data;
`endif
            if ((bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > DEPTH_LIM)) begin
              error    <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= ST_DONE;
            end else begin
              n_words <= CNT_W'(bus.byte_data);
              state   <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ bus.byte_data;
`endif
            if (word_ready) begin
              state   <= ST_WRITE;
              we_q    <= 1'b1;
              waddr_q <= {{(ADDR_W-CNT_W){1'b0}}, word_idx};
              wdata_q <= packed_word;
            end
          end
        end

        ST_WRITE: begin
          word_idx <= word_idx + CNT_W'(1);
          if ((word_idx + CNT_W'(1)) == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            state    <= ST_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else begin
            state <= ST_PAYLOAD;
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (xfer) begin
            if (bus.byte_data == csum) done  <= 1'b1;
            else                       error <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= ST_DONE;
          end
        end
`endif

        default: begin
          state    <= ST_IDLE;
          cpu_hold <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. A reference model derives the expected
// IMEM writes and final flags from each byte stream; expected writes go into a
// scoreboard queue that an independent monitor drains whenever imem_we is seen.
// Build with +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum trailer.
module tb_imem_loader;
  import pegasus_pkg::*;

  localparam int DEPTH = 64;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, error;

  imem_loader_if #(.ADDR_W(32)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus.slave),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  wr_t sb_q[$];
  int  passed = 0;
  int  total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s", name);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.imem_we) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with no write expected",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("imem_waddr", 64'(bus.imem_waddr), 64'(e.addr));
        check("imem_wdata", 64'(bus.imem_wdata), 64'(e.data));
        check("cpu_hold_during_write", 64'(cpu_hold), 64'd1);
      end
    end
  end

  // Reference model: interprets a complete stream per the loader's format rules.
  function automatic void model_load(input byte_q_t s, output bit exp_done, output bit exp_err);
    int n;
    logic [7:0] x;
    n = int'(s[0]);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n == 0 || n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++)
      sb_q.push_back('{addr: 32'(i),
                       data: {s[4*i+4], s[4*i+3], s[4*i+2], s[4*i+1]}});
`ifdef IMEM_LOADER_CHECKSUM_EN
    x = 8'd0;
    for (int j = 0; j <= 4*n; j++) x = x ^ s[j];
    if (s[4*n+1] == x) exp_done = 1'b1;
    else               exp_err  = 1'b1;
`else
    x = 8'd0;
    exp_done = (x == 8'd0);
`endif
  endfunction

  // Appends the checksum trailer when the feature is built in.
  function automatic byte_q_t with_trailer(input byte_q_t s, input bit corrupt);
    byte_q_t r;
    logic [7:0] x;
    r = s;
    x = 8'd0;
    foreach (s[j]) x = x ^ s[j];
`ifdef IMEM_LOADER_CHECKSUM_EN
    r.push_back(corrupt ? ~x : x);
`else
    if (corrupt) x = 8'd0;
`endif
    return r;
  endfunction

  function automatic byte_q_t rand_stream(input int n, input bit corrupt);
    byte_q_t s;
    s.push_back(8'(n));
    for (int i = 0; i < 4*n; i++) s.push_back(8'($urandom_range(0, 255)));
    return with_trailer(s, corrupt);
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  // Drives bytes with optional random valid gaps and spurious start pulses.
  task automatic send_bytes(input byte_q_t s, input bit gaps, input bit noisy_start);
    int  idx = 0;
    int  guard = 0;
    bit  acc;
    @(posedge clk); #1;
    while (idx < s.size()) begin
      if (guard > 5000) begin
        fail_now("stream_stalled");
        break;
      end
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'($urandom_range(0, 255));
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_data  = s[idx];
      end
      start = noisy_start ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      acc = bus.byte_valid && bus.byte_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    bus.byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_finish(input string tag);
    int cyc = 0;
    @(negedge clk);
    while (!(done || error) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    if (!(done || error)) fail_now({tag, "_finish_timeout"});
  endtask

  task automatic run_load(input byte_q_t s, input bit gaps, input bit noisy_start, input string tag);
    bit ed, ee;
    model_load(s, ed, ee);
    pulse_start();
    check({tag, "_hold_after_start"}, 64'(cpu_hold), 64'd1);
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_flags_cleared"}, 64'({done, error}), 64'd0);
    send_bytes(s, gaps, noisy_start);
    wait_finish(tag);
    repeat (2) @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'(ed));
    check({tag, "_error"}, 64'(error), 64'(ee));
    check({tag, "_hold_released"}, 64'(cpu_hold), 64'd0);
    check({tag, "_busy_released"}, 64'(busy), 64'd0);
    check({tag, "_writes_pending"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic idle_bytes_refused(input string tag);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check({tag, "_byte_ready_low"}, 64'(bus.byte_ready), 64'd0);
    end
    @(posedge clk); #1 bus.byte_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_status"}, 64'({cpu_hold, busy, done, error, bus.byte_ready}), 64'd0);
    check({tag, "_we"}, 64'(bus.imem_we), 64'd0);
    check({tag, "_waddr"}, 64'(bus.imem_waddr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
  endtask

  initial begin
    byte_q_t s;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1 reset_n = 1'b1;
    idle_bytes_refused("idle");

    // Directed two-word program
    s = '{8'h02, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(with_trailer(s, 1'b0), 1'b0, 1'b0, "two_words");
    idle_bytes_refused("done");

    // Bad headers, then recovery with a one-word load
    s = '{8'h00};
    run_load(s, 1'b0, 1'b0, "hdr_zero");
    s = '{8'd65};
    run_load(s, 1'b0, 1'b0, "hdr_65");
    s = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00};
    run_load(with_trailer(s, 1'b0), 1'b0, 1'b0, "after_error");
    s = '{8'hFF};
    run_load(s, 1'b0, 1'b0, "hdr_255");

    // Largest program: last address is DEPTH-1
    run_load(rand_stream(DEPTH, 1'b0), 1'b0, 1'b0, "max_depth");

    // Same N=3 program back-to-back and with random valid gaps
    s = rand_stream(3, 1'b0);
    run_load(s, 1'b0, 1'b0, "n3_stream");
    run_load(s, 1'b1, 1'b0, "n3_gaps");

    // Random programs, gaps and ignored start pulses while busy
    for (int k = 0; k < 6; k++)
      run_load(rand_stream($urandom_range(1, 8), 1'b0), 1'b1, k[0], "random");

    // Reset after 6 payload bytes: only the first complete word is written
    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    sb_q.push_back('{addr: 32'd0, data: 32'h4433_2211});
    pulse_start();
    send_bytes(s, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) @(negedge clk);
    check_all_zero("mid_reset_held");
    #1 reset_n = 1'b1;
    check("mid_reset_writes_pending", 64'(sb_q.size()), 64'd0);
    run_load(rand_stream(2, 1'b0), 1'b0, 1'b0, "post_reset");

`ifdef IMEM_LOADER_CHECKSUM_EN
    s = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    run_load(s, 1'b0, 1'b0, "cs_good");
    s = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h00};
    run_load(s, 1'b0, 1'b0, "cs_bad");
    run_load(rand_stream(4, 1'b1), 1'b1, 1'b0, "cs_rand_bad");
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
